// File: rtl/slave_2k_split.sv
// rtl/slave_2k_split.sv - 2Kx32 word-addressed bus slave memory with split-transaction support
module slave_2k_split (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic [15:0] i_haddr,
  input  logic [31:0] i_hwdata,
  input  logic [1:0]  i_hmas,
  input  logic        i_mlock,
  input  logic        i_usplit,
  output logic [31:0] o_hrdata,
  output logic [1:0]  o_hresp,
  output logic        o_hready,
  output logic [1:0]  o_hsplit,
  output logic        o_ab
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_DONE, S_SPLIT1, S_SPLIT2, S_SWAIT, S_RELEASE, S_RESUME
  } state_t;

  state_t      r_state;
  logic [10:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [1:0]  r_mas;
  logic        r_lock;
  logic        r_nosplit;
  logic [31:0] r_hrdata;
  logic        r_hready;
  logic [1:0]  r_hresp;
  logic        r_ab;
  logic [1:0]  r_hsplit;
  logic [31:0] r_mem [2048];

  logic w_split;
  logic w_commit;
  logic w_retry;
  logic w_unused;

  // Address bits 14:13 and 11 carry no meaning for this slave
  assign w_unused = ^{i_haddr[14:13], i_haddr[11]};

  // A resumed transfer is never split a second time, nor is a locked or master-0 transfer
  assign w_split  = i_usplit && !r_lock && (r_mas != 2'b00) && !r_nosplit;
  assign w_commit = (r_state == S_ACCESS) && !w_split && r_write;

  // Other masters get RETRY in the same cycle they knock while a split is outstanding
  assign w_retry = ((r_state == S_SWAIT) && i_sel && i_haddr[15]) ||
                   ((r_state == S_RESUME) && i_sel && (i_hmas != r_mas));

  assign o_hrdata = r_hrdata;
  assign o_hresp  = w_retry ? RESP_RETRY : r_hresp;
  assign o_hready = r_hready;
  assign o_hsplit = r_hsplit;
  assign o_ab     = r_ab;

  // Transfer/split state machine with registered bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_mas     <= '0;
      r_lock    <= 1'b0;
      r_nosplit <= 1'b0;
      r_hrdata  <= '0;
      r_hready  <= 1'b1;
      r_hresp   <= RESP_OKAY;
      r_ab      <= 1'b0;
      r_hsplit  <= 2'b00;
    end else begin
      r_hsplit <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (i_sel && i_haddr[15]) begin
            r_addr    <= i_haddr[10:0];
            r_write   <= i_haddr[12];
            r_wdata   <= i_hwdata;
            r_mas     <= i_hmas;
            r_lock    <= i_mlock;
            r_nosplit <= 1'b0;
            r_state   <= S_ACCESS;
            r_hready  <= 1'b0;
            r_hresp   <= RESP_OKAY;
            r_ab      <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (w_split) begin
            r_state  <= S_SPLIT1;
            r_hready <= 1'b0;
            r_hresp  <= RESP_SPLIT;
          end else begin
            r_state  <= S_DONE;
            r_hready <= 1'b1;
            r_hresp  <= RESP_OKAY;
            if (!r_write) r_hrdata <= r_mem[r_addr];
          end
          r_ab <= 1'b1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= RESP_OKAY;
          r_ab     <= 1'b0;
        end
        S_SPLIT1: begin
          r_state  <= S_SPLIT2;
          r_hready <= 1'b1;
          r_hresp  <= RESP_SPLIT;
        end
        S_SPLIT2: begin
          r_state  <= S_SWAIT;
          r_hready <= 1'b1;
          r_hresp  <= RESP_OKAY;
        end
        S_SWAIT: begin
          if (!i_usplit) begin
            r_state  <= S_RELEASE;
            r_hsplit <= r_mas;
          end
        end
        S_RELEASE: begin
          r_state <= S_RESUME;
        end
        S_RESUME: begin
          if (i_sel && (i_hmas == r_mas)) begin
            r_state   <= S_ACCESS;
            r_nosplit <= 1'b1;
            r_hready  <= 1'b0;
            r_hresp   <= RESP_OKAY;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= RESP_OKAY;
          r_ab     <= 1'b0;
        end
      endcase
    end
  end

  // Memory array is deliberately unreset so its contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_commit) r_mem[r_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_slave_2k_split.sv
// tb/tb_slave_2k_split.sv - table-driven scoreboard bench for slave_2k_split
module tb_slave_2k_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [1:0]  hmas = '0;
  logic        mlock = 1'b0;
  logic        usplit = 1'b0;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        hready;
  logic [1:0]  hsplit;
  logic        ab;

  always #5 clk = ~clk;

  slave_2k_split dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_haddr(haddr), .i_hwdata(hwdata),
    .i_hmas(hmas), .i_mlock(mlock), .i_usplit(usplit), .o_hrdata(hrdata),
    .o_hresp(hresp), .o_hready(hready), .o_hsplit(hsplit), .o_ab(ab)
  );

  typedef struct {
    logic        sel;
    logic [15:0] haddr;
    logic [31:0] wdata;
    logic [1:0]  hmas;
    logic        mlock;
    logic        usplit;
    logic        e_rdy;
    logic [1:0]  e_resp;
    logic [1:0]  e_split;
    logic        e_ab;
    logic        chk;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   split_idx;

  localparam logic [1:0] O = 2'b00;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] S = 2'b11;

  function automatic vec_t mk(logic s, logic [15:0] a, logic [31:0] w, logic [1:0] m,
                              logic l, logic u, logic er, logic [1:0] ep, logic [1:0] es,
                              logic ea, logic c, logic [31:0] ed);
    vec_t v;
    v.sel = s; v.haddr = a; v.wdata = w; v.hmas = m; v.mlock = l; v.usplit = u;
    v.e_rdy = er; v.e_resp = ep; v.e_split = es; v.e_ab = ea; v.chk = c; v.e_data = ed;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    vec_t v;
    vec_t e;
    @(negedge clk);
    v = vt[idx];
    sel = v.sel; haddr = v.haddr; hwdata = v.wdata; hmas = v.hmas;
    mlock = v.mlock; usplit = v.usplit;
    exp_q.push_back(v);
    #2;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard vec %0d: got empty expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      cmp("hready", idx, {31'b0, hready}, {31'b0, e.e_rdy});
      cmp("hresp",  idx, {30'b0, hresp},  {30'b0, e.e_resp});
      cmp("hsplit", idx, {30'b0, hsplit}, {30'b0, e.e_split});
      cmp("ab",     idx, {31'b0, ab},     {31'b0, e.e_ab});
      if (e.chk) cmp("hrdata", idx, hrdata, e.e_data);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    n_vec++;
    cmp({nm, "_hready"}, -1, {31'b0, hready}, 32'd1);
    cmp({nm, "_hresp"},  -1, {30'b0, hresp},  32'd0);
    cmp({nm, "_hsplit"}, -1, {30'b0, hsplit}, 32'd0);
    cmp({nm, "_ab"},     -1, {31'b0, ab},     32'd0);
    cmp({nm, "_hrdata"}, -1, hrdata,          32'd0);
  endtask

  initial begin
    // idle after reset, then write word 3 and read it back
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 0, 1, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 16'h3003, 32'hDEADBEEF, 1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 16'hB003, 32'hDEADBEEF, 1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 1, 1, 32'h0));
    vt.push_back(mk(1, 16'h2003, 32'h0,        1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 16'hA003, 32'h0,        1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 1, 1, 32'hDEADBEEF));
    // top word with ignored address bits set, then read back
    vt.push_back(mk(1, 16'hFFFF, 32'h12345678, 2, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        2, 0, 0, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        2, 0, 0, 1, O, 0, 1, 1, 32'hDEADBEEF));
    vt.push_back(mk(1, 16'hE7FF, 32'h0,        2, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        2, 0, 0, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        2, 0, 0, 1, O, 0, 1, 1, 32'h12345678));
    // split read of word 3, foreign retries, release and resume
    vt.push_back(mk(1, 16'hA003, 32'h0,        1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 0, S, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 1, S, 0, 1, 0, 32'h0));
    vt.push_back(mk(1, 16'hB003, 32'h0,        2, 0, 1, 1, R, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 1, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 1, 1, 0, 32'h0));
    vt.push_back(mk(1, 16'hB003, 32'h0,        2, 0, 0, 1, R, 0, 1, 0, 32'h0));
    vt.push_back(mk(1, 16'h0000, 32'h0,        1, 0, 1, 1, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 1, O, 0, 1, 1, 32'hDEADBEEF));
    // locked transfer and master 0 are never split
    vt.push_back(mk(1, 16'h87FF, 32'h0,        1, 1, 1, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 1, 1, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 1, 1, 1, O, 0, 1, 1, 32'h12345678));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 16'h8003, 32'h0,        0, 0, 1, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        0, 0, 1, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        0, 0, 0, 1, O, 0, 1, 1, 32'hDEADBEEF));
    vt.push_back(mk(0, 16'h0000, 32'h0,        0, 0, 0, 1, O, 0, 0, 0, 32'h0));
    // split write of word 3 that reset will abort
    vt.push_back(mk(1, 16'hB003, 32'h0BADF00D, 1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 0, S, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 1, S, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 1, 1, O, 0, 1, 0, 32'h0));
    split_idx = vt.size();
    // after reset: no pulse, word 3 keeps its earlier value
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 0, 1, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(1, 16'hA003, 32'h0,        1, 0, 0, 1, O, 0, 0, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 0, O, 0, 1, 0, 32'h0));
    vt.push_back(mk(0, 16'h0000, 32'h0,        1, 0, 0, 1, O, 0, 1, 1, 32'hDEADBEEF));

    // reset held low
    @(negedge clk);
    @(negedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < split_idx; i++) apply(i);

    // asynchronous reset in SWAIT
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    usplit = 1'b0;
    #1;
    check_reset_outputs("midsplit_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = split_idx; i < vt.size(); i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
